// File: rtl/cu_pkg.sv
// Shared definitions for the control-unit sequencer: control-word field positions,
// canned control words, phase encoding and PC function selects.
package cu_pkg;

    localparam int CU_CW_W = 33;

    localparam int CW_ALU_EN    = 32;
    localparam int CW_ALU_BS    = 31;
    localparam int CW_ALU_FS_MSB = 30;
    localparam int CW_ALU_FS_LSB = 26;
    localparam int CW_RF_B_EN   = 25;
    localparam int CW_RF_SA_LSB = 20;
    localparam int CW_RF_SB_LSB = 15;
    localparam int CW_RF_DA_LSB = 10;
    localparam int CW_RF_W      = 9;
    localparam int CW_RAM_EN    = 8;
    localparam int CW_RAM_W     = 7;
    localparam int CW_PC_EN     = 6;
    localparam int CW_PC_FS_MSB = 5;
    localparam int CW_PC_FS_LSB = 4;
    localparam int CW_PC_IS     = 3;
    localparam int CW_STATUS_LD = 2;
    localparam int CW_NS_MSB    = 1;
    localparam int CW_NS_LSB    = 0;

    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_INC  = 2'b01;
    localparam logic [1:0] PC_REL  = 2'b10;

    // alu_fs all-ones is the ALU's pass-through/idle function; everything else off.
    localparam logic [CU_CW_W-1:0] NOP_CW   = CU_CW_W'(5'b11111) << CW_ALU_FS_LSB;
    localparam logic [CU_CW_W-1:0] FETCH_CW = NOP_CW | (CU_CW_W'(1) << CW_RAM_EN);

    typedef enum logic [1:0] {
        PH_FETCH = 2'd0,
        PH_EXEC  = 2'd1,
        PH_FAULT = 2'd2
    } phase_t;

endpackage

// File: rtl/cu_status_reg.sv
// Five-bit status flag register with load enable and synchronous active-low reset.
module cu_status_reg (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       load,
    input  logic [4:0] d,
    output logic [4:0] q
);

    // NOTE: sequential state uses non-blocking assignments only; blocking here would
    // create order-dependent simulation races with any reader of q in another block.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            q <= 5'b0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/cu_sequencer.sv
// Multi-cycle control sequencer: fetch handshake into IR, exec-state stepping for the
// decoder bank, control-word gating onto the datapath, and sticky fault on bad decode/overrun.
module cu_sequencer
    import cu_pkg::*;
#(
    parameter int CW_W     = CU_CW_W,
    parameter int MAX_EXEC = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [31:0]     mem_data,
    input  logic            mem_ready,
    input  logic [CW_W-1:0] dec_cw,
    input  logic [63:0]     dec_K,
    input  logic            dec_valid,
    input  logic [4:0]      status_in,
    output logic [31:0]     ir,
    output logic [1:0]      state,
    output logic [4:0]      status,
    output logic [CW_W-1:0] cw_out,
    output logic [63:0]     K_out,
    output logic            fetching,
    output logic            fault
);

    localparam int CNT_W = $clog2(MAX_EXEC) + 1;
    localparam logic [CNT_W-1:0] EXEC_LIMIT = CNT_W'(MAX_EXEC);

    phase_t           phase_q, phase_d;
    logic [31:0]      ir_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d, exec_cnt_inc;
    logic             ir_load;
    logic             status_load;

    assign exec_cnt_inc = exec_cnt_q + 1'b1;

    // NOTE: every output of this block gets a default before the case so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        phase_d     = phase_q;
        state_d     = state_q;
        exec_cnt_d  = exec_cnt_q;
        ir_load     = 1'b0;
        status_load = 1'b0;
        cw_out      = NOP_CW;
        K_out       = '0;

        case (phase_q)
            PH_FETCH: begin
                cw_out = FETCH_CW;
                // The PC only advances for a handshake that will actually be captured.
                if (mem_ready && reset_n) begin
                    cw_out[CW_PC_FS_MSB:CW_PC_FS_LSB] = PC_INC;
                    ir_load    = 1'b1;
                    state_d    = 2'b00;
                    exec_cnt_d = '0;
                    phase_d    = PH_EXEC;
                end
            end

            PH_EXEC: begin
                K_out = dec_K;
                if (!dec_valid) begin
                    phase_d = PH_FAULT;
                    state_d = 2'b00;
                end else begin
                    cw_out      = dec_cw;
                    status_load = dec_cw[CW_STATUS_LD];
                    if (dec_cw[CW_NS_MSB:CW_NS_LSB] == 2'b00) begin
                        phase_d = PH_FETCH;
                        state_d = 2'b00;
                    end else if (exec_cnt_inc == EXEC_LIMIT) begin
                        phase_d = PH_FAULT;
                        state_d = 2'b00;
                    end else begin
                        state_d    = dec_cw[CW_NS_MSB:CW_NS_LSB];
                        exec_cnt_d = exec_cnt_inc;
                    end
                end
            end

            default: begin
                // FAULT and the unused encoding both park here until reset.
                phase_d = PH_FAULT;
                state_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            phase_q    <= PH_FETCH;
            ir_q       <= 32'b0;
            state_q    <= 2'b00;
            exec_cnt_q <= '0;
        end else begin
            phase_q    <= phase_d;
            state_q    <= state_d;
            exec_cnt_q <= exec_cnt_d;
            if (ir_load) begin
                ir_q <= mem_data;
            end
        end
    end

    cu_status_reg u_status_reg (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (status_load),
        .d       (status_in),
        .q       (status)
    );

    assign ir       = ir_q;
    assign state    = state_q;
    assign fetching = (phase_q == PH_FETCH);
    assign fault    = (phase_q == PH_FAULT);

endmodule

// File: tb/tb_cu_sequencer.sv
// Self-checking bench for cu_sequencer: directed scenarios followed by randomized
// traffic, every cycle compared against an instruction-level reference model.
module tb_cu_sequencer;

    localparam int MAX_EXEC = 4;
    localparam logic [32:0] NOP     = 33'h0_7C00_0000;
    localparam logic [32:0] FETCHW  = 33'h0_7C00_0100;
    localparam logic [32:0] PC_PLUS = 33'h0_0000_0010;

    logic        clock;
    logic        reset_n;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic [32:0] dec_cw;
    logic [63:0] dec_K;
    logic        dec_valid;
    logic [4:0]  status_in;
    logic [31:0] ir;
    logic [1:0]  state;
    logic [4:0]  status;
    logic [32:0] cw_out;
    logic [63:0] K_out;
    logic        fetching;
    logic        fault;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: where the instruction is in its life, not how the RTL encodes it.
    bit          m_fetch;
    bit          m_fault;
    logic [31:0] m_ir;
    logic [1:0]  m_state;
    logic [4:0]  m_status;
    int          m_nexec;

    cu_sequencer #(.CW_W(33), .MAX_EXEC(MAX_EXEC)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .dec_cw    (dec_cw),
        .dec_K     (dec_K),
        .dec_valid (dec_valid),
        .status_in (status_in),
        .ir        (ir),
        .state     (state),
        .status    (status),
        .cw_out    (cw_out),
        .K_out     (K_out),
        .fetching  (fetching),
        .fault     (fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [32:0] e_cw;
        logic [63:0] e_k;
        if (m_fault)      e_cw = NOP;
        else if (m_fetch) e_cw = FETCHW | ((mem_ready && reset_n) ? PC_PLUS : 33'h0);
        else              e_cw = dec_valid ? dec_cw : NOP;
        e_k = (!m_fault && !m_fetch) ? dec_K : 64'h0;
        check({tag, ".cw"},       64'(cw_out),   64'(e_cw));
        check({tag, ".k"},        K_out,         e_k);
        check({tag, ".ir"},       64'(ir),       64'(m_ir));
        check({tag, ".state"},    64'(state),    64'(m_state));
        check({tag, ".status"},   64'(status),   64'(m_status));
        check({tag, ".fetching"}, 64'(fetching), 64'(m_fetch && !m_fault));
        check({tag, ".fault"},    64'(fault),    64'(m_fault));
    endtask

    task automatic model_update();
        if (!reset_n) begin
            m_fetch = 1; m_fault = 0; m_ir = '0; m_state = '0; m_status = '0; m_nexec = 0;
        end else if (m_fault) begin
            m_fetch = 0;
        end else if (m_fetch) begin
            if (mem_ready) begin
                m_ir = mem_data; m_state = '0; m_fetch = 0; m_nexec = 0;
            end
        end else begin
            m_nexec++;
            if (!dec_valid) begin
                m_fault = 1; m_state = '0;
            end else begin
                if (dec_cw[2]) m_status = status_in;
                if (dec_cw[1:0] == 2'b00) begin
                    m_fetch = 1; m_state = '0;
                end else if (m_nexec == MAX_EXEC) begin
                    m_fault = 1; m_state = '0;
                end else begin
                    m_state = dec_cw[1:0];
                end
            end
        end
    endtask

    // Inputs are already driven (edge+1); compare at edge+2, then clock and advance the model.
    task automatic cycle(input string tag);
        #1;
        check_outputs(tag);
        @(posedge clock);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic set_exec(input bit valid, input logic [1:0] ns, input bit sl);
        dec_cw[31:0] = $urandom;
        dec_cw[32]   = 1'($urandom_range(0, 1));
        dec_cw[1:0]  = ns;
        dec_cw[2]    = sl;
        dec_K        = {$urandom, $urandom};
        dec_valid    = valid;
    endtask

    task automatic do_fetch(input logic [31:0] word);
        mem_ready = 1'b1;
        mem_data  = word;
        cycle("fetch");
        mem_ready = 1'b0;
        mem_data  = $urandom;
    endtask

    initial begin
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        mem_data  = $urandom;
        status_in = 5'b11111;
        set_exec(1'b1, 2'b01, 1'b1);
        m_fetch = 1; m_fault = 0; m_ir = '0; m_state = '0; m_status = '0; m_nexec = 0;

        // Reset held two cycles with mem_ready high: no PC increment, no IR load.
        @(posedge clock);
        model_update();
        #1;
        cycle("reset");
        check("reset.cw_fetch", 64'(cw_out), 64'(FETCHW));
        reset_n = 1'b1;

        // Fetch wait then handshake.
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle("fetch_wait");
        mem_data  = 32'h1400_0004;
        mem_ready = 1'b1;
        #1;
        check("handshake.pc_fs", 64'(cw_out[5:4]), 64'(2'b01));
        cycle("handshake");
        mem_ready = 1'b0;

        // Two-cycle instruction: state 0 -> 1 -> back to FETCH.
        set_exec(1'b1, 2'b01, 1'b0);
        #1;
        check("exec.cw_pass", 64'(cw_out), 64'(dec_cw));
        check("exec.ir", 64'(ir), 64'(32'h1400_0004));
        cycle("exec0");
        set_exec(1'b1, 2'b00, 1'b0);
        cycle("exec1");
        cycle("back_to_fetch");

        // Status load then hold.
        do_fetch($urandom);
        status_in = 5'b10101;
        set_exec(1'b1, 2'b01, 1'b1);
        cycle("status_ld");
        status_in = 5'b01010;
        set_exec(1'b1, 2'b00, 1'b0);
        cycle("status_hold");
        check("status.value", 64'(status), 64'(5'b10101));

        // Unrecognised opcode: NOP on the bus, sticky fault until reset.
        do_fetch($urandom);
        set_exec(1'b0, 2'b01, 1'b0);
        cycle("illegal");
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_exec(1'b1, 2'b01, 1'b1);
            cycle("fault_hold");
        end
        mem_ready = 1'b0;
        reset_n = 1'b0;
        cycle("fault_reset");
        reset_n = 1'b1;

        // Exec overrun: four non-terminating exec cycles.
        do_fetch($urandom);
        for (int i = 0; i < MAX_EXEC; i++) begin
            set_exec(1'b1, 2'($urandom_range(1, 3)), 1'b0);
            cycle("overrun");
        end
        cycle("overrun_fault");
        reset_n = 1'b0;
        cycle("overrun_reset");
        reset_n = 1'b1;

        // Reset mid-EXEC wins over status load and state step.
        do_fetch($urandom);
        set_exec(1'b1, 2'b10, 1'b0);
        cycle("mid_exec0");
        status_in = 5'b11011;
        set_exec(1'b1, 2'b11, 1'b1);
        reset_n = 1'b0;
        cycle("mid_exec_reset");
        reset_n = 1'b1;
        cycle("after_mid_reset");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            reset_n   = ($urandom_range(0, 39) != 0);
            mem_ready = 1'($urandom_range(0, 1));
            mem_data  = $urandom;
            status_in = 5'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                set_exec(1'b0, 2'($urandom), 1'b0);
            end else begin
                set_exec(1'b1, ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(1, 3)),
                         1'($urandom_range(0, 1)));
            end
            cycle("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
